// File: rtl/eos_tx_serializer.sv
// rtl/eos_tx_serializer.sv - framed serial transmitter with word FIFO and PRBS7 training bursts
module eos_tx_serializer #(
   parameter int   WORD_WIDTH    = 8,
   parameter int   FIFO_DEPTH    = 4,
   parameter int   PREAMBLE_BITS = 32,
   parameter logic IDLE_BIT      = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WORD_WIDTH-1:0]       in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        train_start,
   output logic                        mod_data,
   output logic                        mod_en,
   output logic                        training,
   output logic                        underflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam int MAXB   = (PREAMBLE_BITS > WORD_WIDTH) ? PREAMBLE_BITS : WORD_WIDTH;
   localparam int BCNT_W = $clog2(MAXB + 1);

   // START exists so a back-to-back frame chosen in STOP still gets its own start-bit cycle
   typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_START, S_DATA, S_STOP} state_t;

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0]     count_q;
   logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
   logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [6:0]            lfsr_q, lfsr_d;
   logic                  pend_q, pend_d;
   logic                  prev_stop_q;
   logic                  mod_data_q, mod_data_d;
   logic                  mod_en_q, mod_en_d;
   logic                  training_q, training_d;
   logic                  underflow_q, underflow_d;
   logic                  push, pop, train_req;

   assign in_ready   = (count_q != FCNT_W'(FIFO_DEPTH));
   assign push       = in_valid && in_ready;
   assign train_req  = pend_q || train_start;
   assign fifo_count = count_q;
   assign mod_data   = mod_data_q;
   assign mod_en     = mod_en_q;
   assign training   = training_q;
   assign underflow  = underflow_q;

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + FCNT_W'(1);
            2'b01:   count_q <= count_q - FCNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Next-state and next-output decision; every output is registered one cycle later
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      lfsr_d      = lfsr_q;
      pend_d      = pend_q;
      mod_data_d  = IDLE_BIT;
      mod_en_d    = 1'b0;
      training_d  = 1'b0;
      underflow_d = 1'b0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (train_req) begin
               pend_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = S_TRAIN;
            end else if (count_q != '0) begin
               pop        = 1'b1;
               shreg_d    = mem_q[rd_ptr_q];
               mod_data_d = 1'b1;
               mod_en_d   = 1'b1;
               bit_cnt_d  = '0;
               state_d    = S_DATA;
            end else if (prev_stop_q) begin
               underflow_d = 1'b1;
            end
         end
         S_TRAIN: begin
            mod_data_d = lfsr_q[6];
            mod_en_d   = 1'b1;
            training_d = 1'b1;
            lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            if (bit_cnt_q == BCNT_W'(PREAMBLE_BITS - 1)) state_d = S_IDLE;
            else bit_cnt_d = bit_cnt_q + BCNT_W'(1);
         end
         S_START: begin
            if (train_start) pend_d = 1'b1;
            pop        = 1'b1;
            shreg_d    = mem_q[rd_ptr_q];
            mod_data_d = 1'b1;
            mod_en_d   = 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
         end
         S_DATA: begin
            if (train_start) pend_d = 1'b1;
            mod_data_d = shreg_q[0];
            mod_en_d   = 1'b1;
            shreg_d    = shreg_q >> 1;
            if (bit_cnt_q == BCNT_W'(WORD_WIDTH - 1)) state_d = S_STOP;
            else bit_cnt_d = bit_cnt_q + BCNT_W'(1);
         end
         S_STOP: begin
            if (train_start) pend_d = 1'b1;
            mod_data_d = 1'b0;
            mod_en_d   = 1'b1;
            if (count_q != '0 && !train_req) state_d = S_START;
            else state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame or burst in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         lfsr_q      <= 7'h7F;
         pend_q      <= 1'b0;
         prev_stop_q <= 1'b0;
         mod_data_q  <= IDLE_BIT;
         mod_en_q    <= 1'b0;
         training_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         lfsr_q      <= lfsr_d;
         pend_q      <= pend_d;
         prev_stop_q <= (state_q == S_STOP);
         mod_data_q  <= mod_data_d;
         mod_en_q    <= mod_en_d;
         training_q  <= training_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_eos_tx_serializer.sv
// tb/tb_eos_tx_serializer.sv - self-checking bench for eos_tx_serializer
module tb_eos_tx_serializer;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int P  = 32;
   localparam int TR = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         train_start;
   logic         mod_data;
   logic         mod_en;
   logic         training;
   logic         underflow;
   logic [2:0]   fifo_count;

   eos_tx_serializer #(
      .WORD_WIDTH(W), .FIFO_DEPTH(D), .PREAMBLE_BITS(P), .IDLE_BIT(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .train_start(train_start), .mod_data(mod_data), .mod_en(mod_en), .training(training),
      .underflow(underflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // model: queued words, schedule of future output symbols {train,en,data}
   int  mq[$];
   int  sched[$];
   int  sent_q[$];
   bit  pend, b2b, after_stop, in_frame, model_valid = 1'b0;
   int  pidx;
   bit  prbs[127];
   bit  exp_data, exp_en, exp_train, exp_uf;
   int  dec_cnt;
   logic [W-1:0] dec_word;
   bit  tr_data[TR];
   bit  tr_en[TR];
   bit  tr_train[TR];
   bit  tr_uf[TR];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic start_frame();
      int w;
      w = mq.pop_front();
      sched.push_back(3);
      for (int b = 0; b < W; b++) sched.push_back(2 | ((w >> b) & 1));
      sched.push_back(2);
      in_frame = 1'b1;
   endtask

   task automatic model_reset();
      mq.delete(); sched.delete(); sent_q.delete();
      pend = 0; b2b = 0; after_stop = 0; in_frame = 0; pidx = 0; dec_cnt = 0;
      exp_data = 0; exp_en = 0; exp_train = 0; exp_uf = 0;
      model_valid = 1'b1;
   endtask

   task automatic model_step();
      bit push_ok;
      int sym;
      push_ok = in_valid && (mq.size() != D);
      exp_uf  = 1'b0;
      if (sched.size() == 0) begin
         if (b2b) begin
            b2b = 1'b0;
            if (train_start) pend = 1'b1;
            start_frame();
         end else if (pend || train_start) begin
            pend = 1'b0;
            in_frame = 1'b0;
            sched.push_back(0);
            for (int b = 0; b < P; b++) begin
               sched.push_back(6 | int'(prbs[pidx]));
               pidx = (pidx + 1) % 127;
            end
         end else if (mq.size() != 0) begin
            start_frame();
         end else begin
            if (after_stop) exp_uf = 1'b1;
            in_frame = 1'b0;
            sched.push_back(0);
         end
         after_stop = 1'b0;
      end else if (in_frame && train_start) begin
         pend = 1'b1;
      end
      sym       = sched.pop_front();
      exp_data  = (sym & 1) != 0;
      exp_en    = (sym & 2) != 0;
      exp_train = (sym & 4) != 0;
      if (in_frame && sched.size() == 0) begin
         b2b        = (mq.size() != 0) && !pend;
         after_stop = !b2b;
      end
      if (push_ok) begin
         mq.push_back(int'(in_data));
         sent_q.push_back(int'(in_data));
      end
   endtask

   task automatic decode();
      if (mod_en && !training) begin
         if (dec_cnt == 0) begin
            chk("start_bit", mod_data, 1);
            dec_cnt = 1;
         end else if (dec_cnt <= W) begin
            dec_word[dec_cnt-1] = mod_data;
            dec_cnt++;
         end else begin
            chk("stop_bit", mod_data, 0);
            chk("word_avail", int'(sent_q.size() > 0), 1);
            if (sent_q.size() > 0) chk("word_order", int'(dec_word), sent_q.pop_front());
            dec_cnt = 0;
         end
      end else if (dec_cnt != 0) begin
         chk("frame_contig", int'(mod_en && !training), 1);
         dec_cnt = 0;
      end
   endtask

   // compare process: check outputs against the model, then advance the model
   always @(negedge clk) begin
      if (model_valid) begin
         chk("mod_data", mod_data, exp_data);
         chk("mod_en", mod_en, exp_en);
         chk("training", training, exp_train);
         chk("underflow", underflow, exp_uf);
         chk("in_ready", in_ready, int'(mq.size() != D));
         chk("fifo_count", fifo_count, mq.size());
         decode();
      end
      if (cyc < TR) begin
         tr_data[cyc] = mod_data; tr_en[cyc] = mod_en;
         tr_train[cyc] = training; tr_uf[cyc] = underflow;
      end
      if (rst) model_reset();
      else if (model_valid) model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, t, k, g, cnt;
      bit acc;
      bit [9:0]  a5_bits;
      bit [13:0] pr_bits;
      bit [9:0]  c3_bits;
      int bp_words[5];
      a5_bits  = 10'b0101001011;
      pr_bits  = 14'b10000001111111;
      c3_bits  = 10'b0001111001;
      bp_words = '{8'h11, 8'hE2, 8'h3B, 8'hC4, 8'h5D};
      for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
      for (int i = 0; i < 120; i++) prbs[i+7] = prbs[i] ^ prbs[i+1];

      rst = 1; in_valid = 0; in_data = '0; train_start = 0;
      tick(); tick(); rst = 0;
      chk("rst_mod_data", mod_data, 0);
      chk("rst_mod_en", mod_en, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fifo_count", fifo_count, 0);
      repeat (5) tick();

      // single word 8'hA5
      n = cyc; in_valid = 1; in_data = 8'hA5; tick(); in_valid = 0;
      repeat (14) tick();
      for (int i = 0; i < 10; i++) begin
         chk("a5_bit", tr_data[n+2+i], a5_bits[i]);
         chk("a5_en", tr_en[n+2+i], 1);
      end
      chk("a5_en_before", tr_en[n+1], 0);
      chk("a5_underflow", tr_uf[n+12], 1);
      chk("a5_uf_early", tr_uf[n+11], 0);
      repeat (3) tick();

      // first training burst after reset
      t = cyc; train_start = 1; tick(); train_start = 0;
      repeat (40) tick();
      cnt = 0;
      for (int i = t; i <= t + 40; i++) cnt += int'(tr_train[i]);
      chk("train_len", cnt, 32);
      chk("train_first", tr_train[t+2], 1);
      chk("train_pre", tr_train[t+1], 0);
      chk("train_last", tr_train[t+33], 1);
      chk("train_post", tr_train[t+34], 0);
      for (int i = 0; i < 14; i++) chk("prbs_bit", tr_data[t+2+i], pr_bits[i]);

      // backpressure: words queue up behind a training burst
      train_start = 1; tick(); train_start = 0;
      k = 0; g = 0; in_valid = 1;
      while (k < 5 && g < 200) begin
         in_data = bp_words[k];
         acc = in_ready;
         tick(); g++;
         if (acc) begin
            k++;
            if (k == 4) begin
               chk("bp_count4", fifo_count, 4);
               chk("bp_ready_low", in_ready, 0);
            end
         end
      end
      in_valid = 0;
      chk("bp_all_pushed", k, 5);
      repeat (100) tick();

      // train request at payload bit 3 with two words queued
      n = cyc; in_valid = 1;
      in_data = 8'h96; tick(); in_data = 8'h0F; tick(); in_data = 8'hF0; tick();
      in_valid = 0;
      while (cyc < n + 6) tick();
      train_start = 1; tick(); train_start = 0;
      repeat (60) tick();
      chk("tf_stop_en", tr_en[n+11], 1);
      chk("tf_stop_bit", tr_data[n+11], 0);
      chk("tf_gap", tr_en[n+12], 0);
      chk("tf_train_on", tr_train[n+13], 1);
      chk("tf_train_end", tr_train[n+44], 1);
      chk("tf_resume_start", tr_data[n+45], 1);
      chk("tf_resume_en", tr_en[n+45], 1);
      chk("tf_resume_notrain", tr_train[n+45], 0);
      repeat (40) tick();

      // reset at payload bit 4
      n = cyc; in_valid = 1;
      in_data = 8'h77; tick(); in_data = 8'h88; tick(); in_valid = 0;
      while (cyc < n + 7) tick();
      rst = 1; tick(); rst = 0;
      chk("mid_rst_mod_en", mod_en, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_training", training, 0);
      repeat (3) tick();
      n = cyc; in_valid = 1; in_data = 8'h3C; tick(); in_valid = 0;
      repeat (14) tick();
      for (int i = 0; i < 10; i++) chk("post_rst_bit", tr_data[n+2+i], c3_bits[i]);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         in_valid    = ($urandom_range(0, 99) < 35);
         in_data     = W'($urandom);
         train_start = ($urandom_range(0, 199) == 0);
         rst         = ($urandom_range(0, 999) == 0);
         tick();
      end
      in_valid = 0; train_start = 0; rst = 0;
      g = 0;
      while ((mq.size() != 0 || sched.size() != 0) && g < 600) begin
         tick(); g++;
      end
      chk("drain_bound", int'(g < 600), 1);
      repeat (4) tick();
      chk("drain_sent", sent_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eos_tx_serializer.md
Name: eos_tx_serializer

Overview:
- Digital transmit back end for the electro-optical link. It is the transmitter paired with the current-integrating receiver on the far end.
- Accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. It frames and serializes the words one bit per clock onto the modulator-driver data input.
- On request, it emits a PRBS7 training burst. The receiver uses this burst to calibrate its sense-amp threshold code.
- clk runs at the link bit rate: one cycle = one bit period, 400 ps nominal.

Parameters:
- WORD_WIDTH, 8: payload bits per word.
- FIFO_DEPTH, 4: word buffer entries; power of two, ≥2.
- PREAMBLE_BITS, 32: PRBS7 bits per training burst, 1..1023.
- IDLE_BIT, 0: level driven on mod_data when idle.

Ports:
- clk, in, 1: bit clock.
- rst, in, 1: synchronous reset, active high.
- in_data, in, WORD_WIDTH: word to transmit.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: FIFO can accept a word.
- train_start, in, 1: single-cycle request for a training burst.
- mod_data, out, 1: serial bit to the modulator driver (1 = bit-one drive).
- mod_en, out, 1: high while a frame or burst bit is on mod_data.
- training, out, 1: high while mod_data carries PRBS bits.
- underflow, out, 1: one-cycle pulse; see IDLE.
- fifo_count, out, clog2(FIFO_DEPTH)+1: occupancy.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - FIFO emptied; FSM goes to IDLE; PRBS LFSR = 7'h7F; pending-train flag cleared.
  - Outputs: mod_data = IDLE_BIT, mod_en = 0, training = 0, underflow = 0, fifo_count = 0, in_ready = 1 (first cycle after reset).
  - Reset mid-frame or mid-burst aborts immediately; the partial word is lost.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from state only.
  - Push on in_valid && in_ready. Pop happens when the FSM issues a start bit.
  - Push and pop in the same cycle leave the count unchanged.
  - Words leave in push order.
- mod_data, mod_en and training are registered. A state decision made in cycle k appears on the outputs in cycle k+1.
- FSM states and transitions:
  - IDLE:
    - If the pending-train flag or train_start is set → TRAIN. Training has priority over FIFO data.
    - Else if fifo_count > 0 → pop, emit start bit 1 → DATA.
    - Else emit IDLE_BIT with mod_en = 0.
    - underflow pulses for one cycle on the first IDLE cycle after a STOP, only when the FIFO was empty and no train request was pending.
  - TRAIN:
    - Emit LFSR bit 6, then shift with feedback x^7+x^6+1 (new bit0 = b6 ^ b5).
    - training = 1 and mod_en = 1 for exactly PREAMBLE_BITS cycles, then → IDLE.
    - The LFSR is not reseeded between bursts; only reset reseeds it.
    - A train_start received during TRAIN is ignored.
  - DATA:
    - Emit the popped word LSB first, WORD_WIDTH cycles, then → STOP.
  - STOP:
    - Emit 0 with mod_en = 1.
    - If the FIFO is non-empty and no train request is pending, pop and emit the next start bit in the following cycle (back-to-back frame, no idle gap). Otherwise → IDLE.
- Frame length is WORD_WIDTH+2 cycles, so sustained throughput is one word per WORD_WIDTH+2 cycles.
- train_start during DATA or STOP sets the pending-train flag. The burst follows the stop bit and pre-empts any queued words.
- Latency: with the FIFO empty and the FSM in IDLE, a word pushed in cycle N puts its start bit on mod_data in cycle N+2. Payload bit i appears in cycle N+3+i.

Test Plan:
- Reset state: after reset → mod_data = 0, mod_en = 0, in_ready = 1, fifo_count = 0.
- Single word: push 8'hA5 in cycle 10 → mod_data cycles 12..21 = 1,1,0,1,0,0,1,0,1,0; mod_en high cycles 12..21; underflow pulse in cycle 22.
- Back-to-back and backpressure: push 5 words with in_valid held high → in_ready low after the 4th push until the first pop. Frames are contiguous with no idle gap, and no words are lost or reordered.
- Training burst: train_start in IDLE → 32 bits matching PRBS7 from seed 7F (first bits 1,1,1,1,1,1,1,0). training is high for exactly 32 cycles. A second burst continues the sequence without reseeding.
- Train during a frame: train_start at payload bit 3 with 2 words queued → the current frame completes with its stop bit, then the burst runs, then the queued words are sent.
- Reset mid-frame: rst at payload bit 4 → next cycle mod_en = 0 and fifo_count = 0; a new push afterwards is transmitted correctly.
